// File: rtl/mips_alu_pkg.sv
// Shared encodings for the EX-stage ALU control and the iterative mul/div unit.
// ALU codes, ALUOp values, funct fields, writeback selects and MDU states.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SLTU    = 4'b1000;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_HI  = 2'b01;
  localparam logic [1:0] RES_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic is_mdu(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) ||
           (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_mfx(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide,
// one bit per step, with sign fix-up and divide-by-zero result forming.
module mdu_iter
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_run,
  input  logic             i_signed,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sa;
  logic               r_sb;
  logic               r_sgn;
  logic               r_div;
  logic               r_dz;

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_amag;
  logic [WIDTH-1:0]   w_bmag;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_f;
  logic [WIDTH-1:0]   w_quo_f;
  logic [WIDTH-1:0]   w_rem_f;

  assign w_sa   = i_signed & i_a[WIDTH-1];
  assign w_sb   = i_signed & i_b[WIDTH-1];
  assign w_amag = w_sa ? -i_a : i_a;
  assign w_bmag = w_sb ? -i_b : i_b;
  assign o_dz   = i_is_div & (i_b == '0);
  assign o_last = (r_cnt == CNT_W'(1));

  assign w_madd  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});
  assign w_diff  = w_shift - {1'b0, r_m};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_sgn <= 1'b0;
      r_div <= 1'b0;
      r_dz  <= 1'b0;
    end else if (i_start) begin
      r_sa  <= w_sa;
      r_sb  <= w_sb;
      r_sgn <= i_signed;
      r_div <= i_is_div;
      r_dz  <= o_dz;
      r_cnt <= CNT_W'(WIDTH);
      if (o_dz) begin
        r_acc <= i_a;
        r_q   <= '0;
        r_m   <= '0;
      end else if (i_is_div) begin
        r_acc <= '0;
        r_q   <= w_amag;
        r_m   <= w_bmag;
      end else begin
        r_acc <= '0;
        r_q   <= w_bmag;
        r_m   <= w_amag;
      end
    end else if (i_run) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_div) begin
        r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end else begin
        r_acc <= w_madd[WIDTH:1];
        r_q   <= {w_madd[0], r_q[WIDTH-1:1]};
      end
    end
  end

  // Magnitudes were iterated; signs are restored once at the end.
  assign w_prod   = {r_acc, r_q};
  assign w_prod_f = (r_sgn & (r_sa ^ r_sb)) ? -w_prod : w_prod;
  assign w_quo_f  = (r_sgn & (r_sa ^ r_sb)) ? -r_q : r_q;
  assign w_rem_f  = (r_sgn & r_sa) ? -r_acc : r_acc;

  always_comb begin
    o_hi = w_prod_f[2*WIDTH-1:WIDTH];
    o_lo = w_prod_f[WIDTH-1:0];
    if (r_dz) begin
      o_hi = r_acc;
      o_lo = '1;
    end else if (r_div) begin
      o_hi = w_rem_f;
      o_lo = w_quo_f;
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decode plus HI/LO multiply/divide sequencer.
// Non-MDU instructions flow while the unit iterates; HI/LO users stall.
module alu_control_mdu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             issue,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_ctl,
  output logic             illegal,
  output logic [1:0]       res_sel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mdu_busy,
  output logic             stall,
  output logic             div_zero
);

  mdu_state_e       r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_dz;

  logic             w_rtype;
  logic             w_mdu_op;
  logic             w_mfx;
  logic             w_accept;
  logic             w_signed;
  logic             w_is_div;
  logic             w_last;
  logic             w_dz;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  always_comb begin
    alu_ctl = ALU_ILLEGAL;
    illegal = 1'b0;
    res_sel = RES_ALU;
    unique case (alu_op)
      ALUOP_MEM: alu_ctl = ALU_ADD;
      ALUOP_BEQ: alu_ctl = ALU_SUB;
      ALUOP_ORI: alu_ctl = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_ctl = ALU_ADD;
          F_SUB, F_SUBU: alu_ctl = ALU_SUB;
          F_AND:         alu_ctl = ALU_AND;
          F_OR:          alu_ctl = ALU_OR;
          F_XOR:         alu_ctl = ALU_XOR;
          F_NOR:         alu_ctl = ALU_NOR;
          F_SLT:         alu_ctl = ALU_SLT;
          F_SLTU:        alu_ctl = ALU_SLTU;
          F_MFHI: begin
            alu_ctl = ALU_ADD;
            res_sel = RES_HI;
          end
          F_MFLO: begin
            alu_ctl = ALU_ADD;
            res_sel = RES_LO;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU:
            alu_ctl = ALU_ADD;
          default:       illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign w_rtype  = (alu_op == ALUOP_RTYPE);
  assign w_mdu_op = w_rtype & is_mdu(funct);
  assign w_mfx    = w_rtype & is_mfx(funct);
  assign stall    = issue & r_busy & (w_mdu_op | w_mfx);
  assign w_accept = issue & ~stall & w_mdu_op & (r_state == ST_IDLE);
  assign w_signed = (funct == F_MULT) | (funct == F_DIV);
  assign w_is_div = (funct == F_DIV) | (funct == F_DIVU);

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept),
    .i_run    (r_state == ST_RUN),
    .i_signed (w_signed),
    .i_is_div (w_is_div),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_last   (w_last),
    .o_dz     (w_dz),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_dz <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            // A zero divisor has nothing to iterate over.
            if (w_dz) begin
              r_state <= ST_FIX;
              r_dz    <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_hi    <= w_hi;
          r_lo    <= w_lo;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign mdu_busy = r_busy;
  assign div_zero = r_dz;

endmodule
